// File: rtl/csr_exec_unit_if.sv
// Pipeline and register-file port bundle for the CSR sequencer.
// slave = sequencer side, master = pipeline/register-file side.
interface csr_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [2:0]      req_funct3;
    logic [11:0]     req_csr;
    logic [XLEN-1:0] req_src;
    logic [4:0]      req_zimm;
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_tval;
    logic [XLEN-1:0] trap_pc;
    logic            mret_valid;
    logic            ready;
    logic            done;
    logic [XLEN-1:0] rd_data;
    logic            illegal;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_w_data;
    logic            csr_w_en;
    logic [XLEN-1:0] csr_r_data;

    modport slave (
        input  req_valid, req_funct3, req_csr, req_src, req_zimm,
        input  trap_valid, trap_cause, trap_tval, trap_pc,
        input  mret_valid, csr_r_data,
        output ready, done, rd_data, illegal,
        output redirect_valid, redirect_pc,
        output csr_addr, csr_w_data, csr_w_en
    );

    modport master (
        output req_valid, req_funct3, req_csr, req_src, req_zimm,
        output trap_valid, trap_cause, trap_tval, trap_pc,
        output mret_valid, csr_r_data,
        input  ready, done, rd_data, illegal,
        input  redirect_valid, redirect_pc,
        input  csr_addr, csr_w_data, csr_w_en
    );
endinterface

// File: rtl/csr_exec_unit.sv
// Zicsr read-modify-write, trap entry and MRET sequencer.
// Sole owner of the CSR register file address/write port.
module csr_exec_unit #(
    parameter int XLEN        = 32,
    parameter int RST_PC_ZERO = 1
) (
    input logic            clock,
    input logic            reset_n,
    csr_exec_unit_if.slave bus
);

    if (RST_PC_ZERO != 1) begin : g_bad_rst_pc
        $error("csr_exec_unit: only RST_PC_ZERO=1 is supported");
    end

    typedef enum logic [3:0] {
        IDLE,
        CSR_OP,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STAT,
        T_VEC,
        M_STAT,
        M_EPC
    } state_t;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    state_t          state;
    logic            done_q;
    logic            illegal_q;
    logic            redir_v_q;
    logic [XLEN-1:0] rd_data_q;
    logic [XLEN-1:0] redir_pc_q;

    logic [11:0]     op_csr;
    logic [2:0]      op_f3;
    logic [XLEN-1:0] op_src;
    logic [4:0]      op_zimm;
    logic [XLEN-1:0] t_cause;
    logic [XLEN-1:0] t_tval;
    logic [XLEN-1:0] t_pc;

    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] csr_new;
    logic            csr_legal;
    logic            csr_skip;
    logic [XLEN-1:0] stat_trap;
    logic [XLEN-1:0] stat_mret;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_target;
    logic [XLEN-1:0] epc_masked;
    logic [XLEN-1:0] pc_masked;

    // Operand select, RMW result and trap/MRET value shaping.
    always_comb begin
        old_val = bus.csr_r_data;
        if (op_f3[2]) begin
            operand = {{(XLEN-5){1'b0}}, op_zimm};
        end else begin
            operand = op_src;
        end
        csr_legal = op_f3[1:0] != 2'b00;
        csr_skip  = op_f3[1] && (op_zimm == 5'd0);
        case (op_f3[1:0])
            2'b01:   csr_new = operand;
            2'b10:   csr_new = old_val | operand;
            2'b11:   csr_new = old_val & ~operand;
            default: csr_new = old_val;
        endcase
        stat_trap    = old_val;
        stat_trap[7] = old_val[3];
        stat_trap[3] = 1'b0;
        stat_mret    = old_val;
        stat_mret[3] = old_val[7];
        stat_mret[7] = 1'b1;
        vec_base   = {old_val[XLEN-1:2], 2'b00};
        epc_masked = vec_base;
        pc_masked  = {t_pc[XLEN-1:2], 2'b00};
        if (old_val[1:0] == 2'b01 && t_cause[XLEN-1]) begin
            vec_target = vec_base + {t_cause[XLEN-3:0], 2'b00};
        end else begin
            vec_target = vec_base;
        end
    end

    // Register-file port: one address and at most one write per state.
    always_comb begin
        bus.csr_addr   = 12'h000;
        bus.csr_w_en   = 1'b0;
        bus.csr_w_data = '0;
        case (state)
            CSR_OP: begin
                bus.csr_addr   = op_csr;
                bus.csr_w_en   = csr_legal && !csr_skip;
                bus.csr_w_data = csr_legal ? csr_new : '0;
            end
            T_EPC: begin
                bus.csr_addr   = A_MEPC;
                bus.csr_w_en   = 1'b1;
                bus.csr_w_data = pc_masked;
            end
            T_CAUSE: begin
                bus.csr_addr   = A_MCAUSE;
                bus.csr_w_en   = 1'b1;
                bus.csr_w_data = t_cause;
            end
            T_TVAL: begin
                bus.csr_addr   = A_MTVAL;
                bus.csr_w_en   = 1'b1;
                bus.csr_w_data = t_tval;
            end
            T_STAT: begin
                bus.csr_addr   = A_MSTATUS;
                bus.csr_w_en   = 1'b1;
                bus.csr_w_data = stat_trap;
            end
            T_VEC: bus.csr_addr = A_MTVEC;
            M_STAT: begin
                bus.csr_addr   = A_MSTATUS;
                bus.csr_w_en   = 1'b1;
                bus.csr_w_data = stat_mret;
            end
            M_EPC: bus.csr_addr = A_MEPC;
            default: ;
        endcase
    end

    // Capture request payloads while idle; only the winner is used.
    always_ff @(posedge clock) begin
        if (state == IDLE) begin
            if (bus.trap_valid) begin
                t_cause <= bus.trap_cause;
                t_tval  <= bus.trap_tval;
                t_pc    <= bus.trap_pc;
            end
            if (bus.req_valid) begin
                op_csr  <= bus.req_csr;
                op_f3   <= bus.req_funct3;
                op_src  <= bus.req_src;
                op_zimm <= bus.req_zimm;
            end
        end
    end

    // Sequencer FSM with registered completion and redirect outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            redir_v_q  <= 1'b0;
            rd_data_q  <= '0;
            redir_pc_q <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            redir_v_q <= 1'b0;
            case (state)
                IDLE: begin
                    priority case (1'b1)
                        bus.trap_valid: state <= T_EPC;
                        bus.mret_valid: state <= M_STAT;
                        bus.req_valid:  state <= CSR_OP;
                        default:        state <= IDLE;
                    endcase
                end
                CSR_OP: begin
                    done_q    <= 1'b1;
                    illegal_q <= !csr_legal;
                    rd_data_q <= csr_legal ? old_val : '0;
                    state     <= IDLE;
                end
                T_EPC:   state <= T_CAUSE;
                T_CAUSE: state <= T_TVAL;
                T_TVAL:  state <= T_STAT;
                T_STAT:  state <= T_VEC;
                T_VEC: begin
                    done_q     <= 1'b1;
                    redir_v_q  <= 1'b1;
                    redir_pc_q <= vec_target;
                    state      <= IDLE;
                end
                M_STAT: state <= M_EPC;
                M_EPC: begin
                    done_q     <= 1'b1;
                    redir_v_q  <= 1'b1;
                    redir_pc_q <= epc_masked;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready          = state == IDLE;
    assign bus.done           = done_q;
    assign bus.illegal        = illegal_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.redirect_valid = redir_v_q;
    assign bus.redirect_pc    = redir_pc_q;

endmodule
